// File: rtl/conv3x3_engine.sv
`default_nettype none
// ============================================================================
// Module      : conv3x3_engine
// Description : Three-stage pipelined 3x3 convolution engine with a
//               valid/ready result stream and a programmable coefficient set.
//               Stage 1 registers the nine tap products.
//               Stage 2 registers their sum.
//               Stage 3 normalises the sum with an arithmetic right shift,
//               clamps it to the pixel range and drives out_pixel.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               enable                - level request to run
//               win_in_1..win_in_9    - 3x3 window, row-major (1 = top-left)
//               buf_valid             - window data valid
//               in_row2_cond          - window rows fully populated
//               win_ready             - engine accepts a window this cycle
//               coef_we/addr/data     - coefficient write port, addr 0..8
//               shift                 - normalisation right-shift, 0..15
//               out_pixel/valid/ready - result stream
//               busy                  - FSM not idle
//               pix_count             - accepted-result counter (wraps)
//               coef_err              - sticky illegal coefficient write
// Options     : CONV_ABS_EN - when defined, stage 3 outputs the magnitude of
//               the shifted sum (edge detection); otherwise negative results
//               clamp to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module conv3x3_engine #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [DATA_W-1:0]        win_in_1,
    input  logic [DATA_W-1:0]        win_in_2,
    input  logic [DATA_W-1:0]        win_in_3,
    input  logic [DATA_W-1:0]        win_in_4,
    input  logic [DATA_W-1:0]        win_in_5,
    input  logic [DATA_W-1:0]        win_in_6,
    input  logic [DATA_W-1:0]        win_in_7,
    input  logic [DATA_W-1:0]        win_in_8,
    input  logic [DATA_W-1:0]        win_in_9,
    input  logic                     buf_valid,
    input  logic                     in_row2_cond,
    output logic                     win_ready,
    input  logic                     coef_we,
    input  logic [3:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    input  logic [3:0]               shift,
    output logic [DATA_W-1:0]        out_pixel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic [15:0]              pix_count,
    output logic                     coef_err
);

    // Product of a zero-extended pixel and a signed coefficient.
    localparam int C_PROD_W = DATA_W + 1 + COEF_W;
    // Four extra bits hold the sum of nine products without overflow.
    localparam int C_SUM_W  = C_PROD_W + 4;
    localparam int C_NTAPS  = 9;
    localparam logic signed [C_SUM_W-1:0] C_PIX_MAX =
        {{(C_SUM_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic signed [COEF_W-1:0]   coef_q [C_NTAPS];
    logic signed [COEF_W-1:0]   coef_d [C_NTAPS];
    logic                       coef_err_q, coef_err_d;
    logic                       v1_q, v1_d;
    logic signed [C_PROD_W-1:0] prod_q [C_NTAPS];
    logic signed [C_PROD_W-1:0] prod_d [C_NTAPS];
    logic                       v2_q, v2_d;
    logic signed [C_SUM_W-1:0]  sum_q, sum_d;
    logic                       v3_q, v3_d;
    logic [DATA_W-1:0]          pix_q, pix_d;
    logic [15:0]                cnt_q, cnt_d;

    logic [DATA_W-1:0]          w_win [C_NTAPS];
    logic                       w_adv1, w_adv2, w_adv3;
    logic                       w_accept;
    logic signed [C_SUM_W-1:0]  w_sum;
    logic signed [C_SUM_W-1:0]  w_shifted;
    logic signed [C_SUM_W-1:0]  w_mag;
    logic [DATA_W-1:0]          w_clamp;

    always_comb begin
        w_win[0] = win_in_1;
        w_win[1] = win_in_2;
        w_win[2] = win_in_3;
        w_win[3] = win_in_4;
        w_win[4] = win_in_5;
        w_win[5] = win_in_6;
        w_win[6] = win_in_7;
        w_win[7] = win_in_8;
        w_win[8] = win_in_9;
    end

    // A stage may load when it is empty or its content moves on this cycle,
    // so bubbles collapse even while the output is stalled.
    always_comb begin
        w_adv3   = !v3_q || out_ready;
        w_adv2   = !v2_q || w_adv3;
        w_adv1   = !v1_q || w_adv2;
        w_accept = (state_q == ST_RUN) && w_adv1 && buf_valid && in_row2_cond;
    end

    // Control FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_RUN;
            ST_RUN:   if (!enable) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (enable)
                    state_d = ST_RUN;
                else if (!v1_q && !v2_q && !v3_q)
                    state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Coefficient bank: writable only while idle, anything else is flagged.
    always_comb begin
        coef_err_d = coef_err_q;
        for (int i = 0; i < C_NTAPS; i++) begin
            coef_d[i] = coef_q[i];
        end
        if (coef_we) begin
            if ((state_q == ST_IDLE) && (coef_addr <= 4'd8)) begin
                for (int i = 0; i < C_NTAPS; i++) begin
                    if (coef_addr == 4'(i)) coef_d[i] = coef_data;
                end
            end else begin
                coef_err_d = 1'b1;
            end
        end
    end

    // Datapath
    always_comb begin
        v1_d  = v1_q;
        v2_d  = v2_q;
        v3_d  = v3_q;
        sum_d = sum_q;
        pix_d = pix_q;
        cnt_d = cnt_q;
        for (int i = 0; i < C_NTAPS; i++) begin
            prod_d[i] = prod_q[i];
        end

        w_sum = '0;
        for (int i = 0; i < C_NTAPS; i++) begin
            w_sum = w_sum + C_SUM_W'(prod_q[i]);
        end

        w_shifted = sum_q >>> shift;
`ifdef CONV_ABS_EN
        w_mag = w_shifted[C_SUM_W-1] ? -w_shifted : w_shifted;
`else
        w_mag = w_shifted;
`endif
        if (w_mag[C_SUM_W-1])
            w_clamp = '0;
        else if (w_mag > C_PIX_MAX)
            w_clamp = '1;
        else
            w_clamp = w_mag[DATA_W-1:0];

        if (w_adv1) begin
            v1_d = w_accept;
            for (int i = 0; i < C_NTAPS; i++) begin
                prod_d[i] = C_PROD_W'($signed({1'b0, w_win[i]})) *
                            C_PROD_W'(coef_q[i]);
            end
        end
        if (w_adv2) begin
            v2_d  = v1_q;
            sum_d = w_sum;
        end
        if (w_adv3) begin
            v3_d = v2_q;
            if (v2_q) pix_d = w_clamp;
        end

        if (v3_q && out_ready) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            coef_err_q <= 1'b0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            sum_q      <= '0;
            pix_q      <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < C_NTAPS; i++) begin
                coef_q[i] <= (i == 4) ? COEF_W'(1) : '0;
                prod_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            coef_err_q <= coef_err_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            v3_q       <= v3_d;
            sum_q      <= sum_d;
            pix_q      <= pix_d;
            cnt_q      <= cnt_d;
            for (int i = 0; i < C_NTAPS; i++) begin
                coef_q[i] <= coef_d[i];
                prod_q[i] <= prod_d[i];
            end
        end
    end

    // Gating with rst keeps any in-flight result from handshaking while
    // the reset is being applied.
    assign out_valid = v3_q && !rst;
    assign win_ready = (state_q == ST_RUN) && w_adv1 && !rst;
    assign out_pixel = pix_q;
    assign busy      = (state_q != ST_IDLE);
    assign pix_count = cnt_q;
    assign coef_err  = coef_err_q;

endmodule
`default_nettype wire
